// File: rtl/hba_gpio_ext.sv
// GPIO peripheral on the HBA slave bus: per-pin direction, synchronised and debounced inputs,
// rise/fall edge selection and sticky write-1-to-clear interrupt status.
module hba_gpio_ext #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_PINS          = 4,
  parameter int DEBOUNCE_RST      = 0
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_slave,
  output logic                  hba_xferack_slave,
  output logic                  slave_interrupt,
  output logic [NUM_PINS-1:0]   gpio_out_en,
  output logic [NUM_PINS-1:0]   gpio_out_sig,
  input  logic [NUM_PINS-1:0]   gpio_in_sig
);

  if (NUM_PINS < 1 || NUM_PINS > DBUS_WIDTH) begin : g_bad_num_pins
    $error("hba_gpio_ext: NUM_PINS must be within 1..DBUS_WIDTH");
  end

  localparam logic [PERIPH_ADDR_WIDTH-1:0] PERIPH_SEL    = PERIPH_ADDR_WIDTH'(PERIPH_ADDR);
  localparam logic [DBUS_WIDTH-1:0]        DEBOUNCE_INIT = DBUS_WIDTH'(DEBOUNCE_RST);
  localparam logic [REG_ADDR_WIDTH-1:0]    OFF_DIR   = REG_ADDR_WIDTH'(0);
  localparam logic [REG_ADDR_WIDTH-1:0]    OFF_PINS  = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0]    OFF_IEN   = REG_ADDR_WIDTH'(2);
  localparam logic [REG_ADDR_WIDTH-1:0]    OFF_RISE  = REG_ADDR_WIDTH'(3);
  localparam logic [REG_ADDR_WIDTH-1:0]    OFF_FALL  = REG_ADDR_WIDTH'(4);
  localparam logic [REG_ADDR_WIDTH-1:0]    OFF_STS   = REG_ADDR_WIDTH'(5);
  localparam logic [REG_ADDR_WIDTH-1:0]    OFF_DEB   = REG_ADDR_WIDTH'(6);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_e;

  bus_state_e                  state_r;
  logic                        ack_r;
  logic [DBUS_WIDTH-1:0]       rdata_r;
  logic                        irq_r;
  logic [NUM_PINS-1:0]         out_en_r;
  logic [NUM_PINS-1:0]         out_sig_r;

  logic [NUM_PINS-1:0]         dir_r;
  logic [NUM_PINS-1:0]         pins_out_r;
  logic [NUM_PINS-1:0]         intr_en_r;
  logic [NUM_PINS-1:0]         rise_en_r;
  logic [NUM_PINS-1:0]         fall_en_r;
  logic [NUM_PINS-1:0]         status_r;
  logic [DBUS_WIDTH-1:0]       debounce_r;

  logic [NUM_PINS-1:0]         sync1_r;
  logic [NUM_PINS-1:0]         sync2_r;
  logic [NUM_PINS-1:0]         filt_r;
  logic [NUM_PINS-1:0]         filt_prev_r;
  logic [DBUS_WIDTH-1:0]       cnt_r [NUM_PINS];

  logic                        periph_hit_s;
  logic [REG_ADDR_WIDTH-1:0]   reg_off_s;
  logic                        xfer_start_s;
  logic                        wr_en_s;
  logic [NUM_PINS-1:0]         wr_pins_s;
  logic [DBUS_WIDTH-1:0]       rd_data_s;
  logic [NUM_PINS-1:0]         edge_set_s;
  logic [NUM_PINS-1:0]         status_clr_s;
  logic [NUM_PINS-1:0]         status_nxt_s;
  logic [NUM_PINS-1:0]         intr_en_nxt_s;

  assign periph_hit_s = (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_SEL);
  assign reg_off_s    = hba_abus[REG_ADDR_WIDTH-1:0];
  assign xfer_start_s = (state_r == ST_IDLE) && hba_select && periph_hit_s;
  assign wr_en_s      = xfer_start_s && !hba_rnw;
  assign wr_pins_s    = hba_dbus[NUM_PINS-1:0];

  // Read-data mux; PINS shows the driven value for outputs and the filtered value for inputs
  always_comb begin
    rd_data_s = {DBUS_WIDTH{1'b0}};
    case (reg_off_s)
      OFF_DIR:  rd_data_s[NUM_PINS-1:0] = dir_r;
      OFF_PINS: rd_data_s[NUM_PINS-1:0] = (dir_r & pins_out_r) | (~dir_r & filt_r);
      OFF_IEN:  rd_data_s[NUM_PINS-1:0] = intr_en_r;
      OFF_RISE: rd_data_s[NUM_PINS-1:0] = rise_en_r;
      OFF_FALL: rd_data_s[NUM_PINS-1:0] = fall_en_r;
      OFF_STS:  rd_data_s[NUM_PINS-1:0] = status_r;
      OFF_DEB:  rd_data_s               = debounce_r;
      default:  rd_data_s               = {DBUS_WIDTH{1'b0}};
    endcase
  end

  // Status next-state: new edge events override a simultaneous write-1-to-clear
  always_comb begin
    edge_set_s = ((filt_r & ~filt_prev_r & rise_en_r) | (~filt_r & filt_prev_r & fall_en_r)) & ~dir_r;
    if (wr_en_s && (reg_off_s == OFF_STS)) begin
      status_clr_s = wr_pins_s;
    end else begin
      status_clr_s = {NUM_PINS{1'b0}};
    end
    if (wr_en_s && (reg_off_s == OFF_IEN)) begin
      intr_en_nxt_s = wr_pins_s;
    end else begin
      intr_en_nxt_s = intr_en_r;
    end
    status_nxt_s = (status_r & ~status_clr_s) | edge_set_s;
  end

  // Bus handshake: one ack per select assertion, then hold off until select drops
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      state_r <= ST_IDLE;
      ack_r   <= 1'b0;
      rdata_r <= {DBUS_WIDTH{1'b0}};
    end else begin
      ack_r   <= 1'b0;
      rdata_r <= {DBUS_WIDTH{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (xfer_start_s) begin
            state_r <= ST_ACK;
            ack_r   <= 1'b1;
            rdata_r <= hba_rnw ? rd_data_s : {DBUS_WIDTH{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACK:  state_r <= ST_WAIT;
        ST_WAIT: state_r <= hba_select ? ST_WAIT : ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Control register writes, committed on the IDLE->ACK edge
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      dir_r      <= {NUM_PINS{1'b0}};
      pins_out_r <= {NUM_PINS{1'b0}};
      intr_en_r  <= {NUM_PINS{1'b0}};
      rise_en_r  <= {NUM_PINS{1'b0}};
      fall_en_r  <= {NUM_PINS{1'b0}};
      debounce_r <= DEBOUNCE_INIT;
    end else if (wr_en_s) begin
      case (reg_off_s)
        OFF_DIR:  dir_r      <= wr_pins_s;
        OFF_PINS: pins_out_r <= wr_pins_s;
        OFF_IEN:  intr_en_r  <= wr_pins_s;
        OFF_RISE: rise_en_r  <= wr_pins_s;
        OFF_FALL: fall_en_r  <= wr_pins_s;
        OFF_DEB:  debounce_r <= hba_dbus;
        default:  dir_r      <= dir_r;
      endcase
    end
  end

  // Sticky status, interrupt level and pin drive registers
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      status_r  <= {NUM_PINS{1'b0}};
      irq_r     <= 1'b0;
      out_en_r  <= {NUM_PINS{1'b0}};
      out_sig_r <= {NUM_PINS{1'b0}};
    end else begin
      status_r  <= status_nxt_s;
      irq_r     <= |(status_nxt_s & intr_en_nxt_s);
      out_en_r  <= dir_r;
      out_sig_r <= pins_out_r & dir_r;
    end
  end

  // Input synchroniser and debounce filter; counter restarts whenever the input agrees with filt
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      sync1_r     <= {NUM_PINS{1'b0}};
      sync2_r     <= {NUM_PINS{1'b0}};
      filt_r      <= {NUM_PINS{1'b0}};
      filt_prev_r <= {NUM_PINS{1'b0}};
      for (int i = 0; i < NUM_PINS; i++) begin
        cnt_r[i] <= {DBUS_WIDTH{1'b0}};
      end
    end else begin
      sync1_r     <= gpio_in_sig;
      sync2_r     <= sync1_r;
      filt_prev_r <= filt_r;
      for (int i = 0; i < NUM_PINS; i++) begin
        if (sync2_r[i] == filt_r[i]) begin
          cnt_r[i] <= {DBUS_WIDTH{1'b0}};
        end else if (cnt_r[i] >= debounce_r) begin
          filt_r[i] <= sync2_r[i];
          cnt_r[i]  <= {DBUS_WIDTH{1'b0}};
        end else begin
          cnt_r[i] <= cnt_r[i] + DBUS_WIDTH'(1);
        end
      end
    end
  end

  assign hba_dbus_slave    = rdata_r;
  assign hba_xferack_slave = ack_r;
  assign slave_interrupt   = irq_r;
  assign gpio_out_en       = out_en_r;
  assign gpio_out_sig      = out_sig_r;

endmodule

// File: tb/tb_hba_gpio_ext.sv
// Directed bench for hba_gpio_ext: bus tasks queue expected ack data, a negedge monitor
// pops and compares on every xferack; pin-level outputs are checked directly.
module tb_hba_gpio_ext;

  logic        hba_clk = 1'b0;
  logic        hba_reset_n = 1'b0;
  logic        hba_rnw = 1'b1;
  logic        hba_select = 1'b0;
  logic [11:0] hba_abus = 12'h000;
  logic [7:0]  hba_dbus = 8'h00;
  logic [7:0]  hba_dbus_slave;
  logic        hba_xferack_slave;
  logic        slave_interrupt;
  logic [3:0]  gpio_out_en;
  logic [3:0]  gpio_out_sig;
  logic [3:0]  gpio_in_sig = 4'h0;

  int          n_vec = 0;
  int          n_miss = 0;
  int          ack_cnt = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mon_exp;

  hba_gpio_ext dut (
    .hba_clk           (hba_clk),
    .hba_reset_n       (hba_reset_n),
    .hba_rnw           (hba_rnw),
    .hba_select        (hba_select),
    .hba_abus          (hba_abus),
    .hba_dbus          (hba_dbus),
    .hba_dbus_slave    (hba_dbus_slave),
    .hba_xferack_slave (hba_xferack_slave),
    .slave_interrupt   (slave_interrupt),
    .gpio_out_en       (gpio_out_en),
    .gpio_out_sig      (gpio_out_sig),
    .gpio_in_sig       (gpio_in_sig)
  );

  always #5 hba_clk = ~hba_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack must match the oldest queued expectation
  always @(negedge hba_clk) begin
    if (hba_xferack_slave === 1'b1) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_ack: got ack with data 0x%0h, expected no ack", hba_dbus_slave);
      end else begin
        mon_exp = exp_q.pop_front();
        check("ack_data", {24'h0, hba_dbus_slave}, {24'h0, mon_exp});
      end
    end
  end

  task automatic xfer(input logic rnw, input logic [3:0] periph, input logic [7:0] off,
                      input logic [7:0] wdata, input logic [7:0] exp, input int hold);
    int a0;
    @(negedge hba_clk);
    a0 = ack_cnt;
    hba_rnw    = rnw;
    hba_abus   = {periph, off};
    hba_dbus   = wdata;
    hba_select = 1'b1;
    if (periph == 4'h0) exp_q.push_back(rnw ? exp : 8'h00);
    repeat (hold) @(negedge hba_clk);
    hba_select = 1'b0;
    @(posedge hba_clk);
    @(posedge hba_clk);
    check("ack_count", 32'(ack_cnt - a0), (periph == 4'h0) ? 32'd1 : 32'd0);
  endtask

  task automatic wr(input logic [7:0] off, input logic [7:0] d);
    xfer(1'b0, 4'h0, off, d, 8'h00, 1);
  endtask

  task automatic rd(input logic [7:0] off, input logic [7:0] exp);
    xfer(1'b1, 4'h0, off, 8'h00, exp, 1);
  endtask

  task automatic set_pins(input logic [3:0] v);
    @(negedge hba_clk);
    gpio_in_sig = v;
  endtask

  initial begin
    // Reset with a transfer already requested
    hba_select = 1'b1;
    hba_rnw    = 1'b1;
    hba_abus   = 12'h000;
    repeat (3) @(negedge hba_clk);
    check("rst_xferack", {31'h0, hba_xferack_slave}, 32'd0);
    check("rst_out_en", {28'h0, gpio_out_en}, 32'd0);
    check("rst_out_sig", {28'h0, gpio_out_sig}, 32'd0);
    check("rst_irq", {31'h0, slave_interrupt}, 32'd0);
    check("rst_dbus", {24'h0, hba_dbus_slave}, 32'd0);
    exp_q.push_back(8'h00);
    hba_reset_n = 1'b1;
    repeat (5) @(negedge hba_clk);
    check("rst_single_ack", 32'(ack_cnt), 32'd1);
    hba_select = 1'b0;
    repeat (2) @(posedge hba_clk);

    // Direction and output drive
    gpio_in_sig = 4'hA;
    wr(8'd0, 8'h05);
    wr(8'd1, 8'h0F);
    @(negedge hba_clk);
    check("out_en", {28'h0, gpio_out_en}, 32'h5);
    check("out_sig", {28'h0, gpio_out_sig}, 32'h5);
    rd(8'd1, 8'h0F);
    rd(8'd0, 8'h05);
    wr(8'd0, 8'hFF);
    rd(8'd0, 8'h0F);
    wr(8'd0, 8'h00);
    wr(8'd1, 8'h00);
    gpio_in_sig = 4'h0;
    repeat (6) @(posedge hba_clk);

    // Debounce of 3: a 3-cycle pulse is filtered, a long level is not
    wr(8'd6, 8'h03);
    rd(8'd6, 8'h03);
    wr(8'd3, 8'h01);
    wr(8'd2, 8'h01);
    set_pins(4'h1);
    repeat (3) @(posedge hba_clk);
    set_pins(4'h0);
    repeat (10) @(posedge hba_clk);
    rd(8'd5, 8'h00);
    check("glitch_irq", {31'h0, slave_interrupt}, 32'd0);
    set_pins(4'h1);
    repeat (10) @(posedge hba_clk);
    rd(8'd5, 8'h01);
    @(negedge hba_clk);
    check("rise_irq", {31'h0, slave_interrupt}, 32'd1);
    wr(8'd5, 8'h01);
    @(negedge hba_clk);
    check("w1c_irq", {31'h0, slave_interrupt}, 32'd0);
    set_pins(4'h0);
    repeat (10) @(posedge hba_clk);
    rd(8'd5, 8'h00);

    // Falling-edge only on pin 1
    wr(8'd6, 8'h00);
    wr(8'd3, 8'h00);
    wr(8'd4, 8'h0F);
    wr(8'd2, 8'h0F);
    set_pins(4'h2);
    repeat (6) @(posedge hba_clk);
    rd(8'd5, 8'h00);
    set_pins(4'h0);
    repeat (6) @(posedge hba_clk);
    rd(8'd5, 8'h02);
    @(negedge hba_clk);
    check("fall_irq", {31'h0, slave_interrupt}, 32'd1);
    wr(8'd5, 8'h02);
    @(negedge hba_clk);
    check("fall_w1c_irq", {31'h0, slave_interrupt}, 32'd0);

    // Falling edge lands on the same edge as the clear of that bit
    set_pins(4'h2);
    repeat (6) @(posedge hba_clk);
    set_pins(4'h0);
    repeat (3) @(posedge hba_clk);
    wr(8'd5, 8'h02);
    rd(8'd5, 8'h02);
    @(negedge hba_clk);
    check("set_wins_irq", {31'h0, slave_interrupt}, 32'd1);

    // Output pins never raise status
    wr(8'd5, 8'h0F);
    wr(8'd3, 8'h0F);
    wr(8'd0, 8'h04);
    set_pins(4'h4);
    repeat (6) @(posedge hba_clk);
    set_pins(4'h0);
    repeat (6) @(posedge hba_clk);
    rd(8'd5, 8'h00);
    wr(8'd0, 8'h00);

    // Unmapped offsets, long select, foreign peripheral
    rd(8'd7, 8'h00);
    rd(8'hFF, 8'h00);
    xfer(1'b1, 4'h0, 8'd6, 8'h00, 8'h00, 5);
    xfer(1'b1, 4'h1, 8'd0, 8'h00, 8'h00, 1);

    @(negedge hba_clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
